// File: rtl/cpu_types_pkg.sv
// Shared types for the core/RAM interconnect and the bus arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Handshake state reported by the RAM each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM; prefixed to avoid clashing with the ramstate_t BUSY literal.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_t;

  // Bit positions in the 4-wide request vector handed to rr_select.
  localparam int unsigned ReqD0 = 0;
  localparam int unsigned ReqI0 = 1;
  localparam int unsigned ReqD1 = 2;
  localparam int unsigned ReqI1 = 3;

endpackage

// File: rtl/bus_arbiter_if.sv
// Core-side requests/stalls plus the single shared RAM port.
interface bus_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0] dREN, dWEN, iREN;
  logic [CPUS-1:0] dwait, iwait;
  word_t           daddr  [CPUS];
  word_t           dstore [CPUS];
  word_t           iaddr  [CPUS];
  word_t           dload  [CPUS];
  word_t           iload  [CPUS];

  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  // Arbiter view: owns the RAM strobes and the per-core stalls.
  modport master (
    input  dREN, dWEN, iREN, daddr, dstore, iaddr, ramload, ramstate,
    output dwait, iwait, dload, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment view: cores and RAM.
  modport slave (
    output dREN, dWEN, iREN, daddr, dstore, iaddr, ramload, ramstate,
    input  dwait, iwait, dload, iload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_select.sv
// Combinational winner pick: pointer core first, data before instruction.
module rr_select (
  input  logic [3:0] req_i,  // {i1, d1, i0, d0}
  input  logic       ptr_i,
  output logic [3:0] gnt_o
);

  logic [1:0] core_req;
  logic       sel;

  // Fall back to the other core only when the pointer core is silent.
  always_comb begin
    core_req[0] = req_i[0] | req_i[1];
    core_req[1] = req_i[2] | req_i[3];
    sel         = core_req[ptr_i] ? ptr_i : ~ptr_i;
    gnt_o       = '0;
    if (|req_i) begin
      if (req_i[{sel, 1'b0}]) begin
        gnt_o[{sel, 1'b0}] = 1'b1;
      end else begin
        gnt_o[{sel, 1'b1}] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-core round-robin arbiter for a single RAM port, with watchdog abort.
module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  bus_arbiter_if.master bus,
  output logic [1:0]    grant,
  output logic          timeout
);

  // Counter value in the last BUSY cycle allowed before abort.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;

  logic [3:0] req, gnt;
  logic       g_cpu, g_data, g_active, busy_drv, done;

  assign req = {bus.iREN[1], bus.dREN[1] | bus.dWEN[1],
                bus.iREN[0], bus.dREN[0] | bus.dWEN[0]};

  rr_select u_rr_select (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Load data is broadcast; only the stall tells a core it is valid.
  for (genvar i = 0; i < CPUS; i++) begin : g_load
    assign bus.dload[i] = bus.ramload;
    assign bus.iload[i] = bus.ramload;
  end

  // RAM drive and stalls follow the granted requester's live inputs.
  always_comb begin
    g_cpu        = grant_q[1];
    g_data       = grant_q[0];
    g_active     = g_data ? (bus.dREN[g_cpu] | bus.dWEN[g_cpu]) : bus.iREN[g_cpu];
    // nRST gating keeps the RAM quiet during the reset cycle itself.
    busy_drv     = (state_q == StBusy) && nRST && g_active;
    done         = busy_drv && (bus.ramstate == ACCESS);
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = '1;
    bus.iwait    = '1;
    if (busy_drv) begin
      if (g_data) begin
        bus.ramWEN   = bus.dWEN[g_cpu];
        bus.ramREN   = bus.dREN[g_cpu] & ~bus.dWEN[g_cpu];
        bus.ramaddr  = bus.daddr[g_cpu];
        bus.ramstore = bus.dstore[g_cpu];
      end else begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[g_cpu];
      end
    end
    if (done) begin
      if (g_data) begin
        bus.dwait[g_cpu] = 1'b0;
      end else begin
        bus.iwait[g_cpu] = 1'b0;
      end
    end
  end

  // Next-state: capture in IDLE; in BUSY finish, drop or time out.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StBusy;
          cnt_d   = '0;
          grant_d = {gnt[ReqD1] | gnt[ReqI1], gnt[ReqD0] | gnt[ReqD1]};
        end
      end
      StBusy: begin
        if (!g_active) begin
          // Requester gave up: no completion, pointer stays put.
          state_d = StIdle;
        end else if (bus.ramstate == ACCESS) begin
          state_d = StIdle;
          ptr_d   = ~g_cpu;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StIdle;
          ptr_d     = ~g_cpu;
          timeout_d = 1'b1;
        end else begin
          // ERROR is simply retried by staying here.
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: vector table, directed corner cases, random vs. model.
module tb_bus_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned Timeout = 255;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [1:0] grant;
  logic       timeout;

  bus_arbiter_if #(.CPUS(2)) bus ();

  bus_arbiter #(.CPUS(2), .TIMEOUT(Timeout)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .bus     (bus),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  dren, dwen, iren;
    logic [1:0]  exp_grant;
    logic        exp_ren, exp_wen;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  // Reference model state (transaction level).
  bit         m_busy, m_cpu, m_data, m_ptr, m_to;
  logic [1:0] m_grant;
  int         m_cnt;

  int busy_cycles;
  bit seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_req();
    bus.dREN = '0; bus.dWEN = '0; bus.iREN = '0;
    for (int i = 0; i < 2; i++) begin
      bus.daddr[i] = '0; bus.dstore[i] = '0; bus.iaddr[i] = '0;
    end
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  // Ends at a negedge with reset released and the DUT idle.
  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    clear_req();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_req();
    vecs[0] = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 32'hA0};
    vecs[1] = '{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 32'hA0};
    vecs[2] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 32'hA0};
    vecs[3] = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 32'hC0};
    vecs[4] = '{2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 32'hA0};
    vecs[5] = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 32'hB0};
    vecs[6] = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 32'hD0};
    vecs[7] = '{2'b01, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 32'hA0};
    vecs[8] = '{2'b00, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, 32'hC0};
    vecs[9] = '{2'b11, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 32'hA0};

    // Reset state.
    do_reset();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_dwait", bus.dwait, 2'b11);
    chk("rst_iwait", bus.iwait, 2'b11);
    chk("rst_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);

    // Single-transaction table from a fresh reset (pointer 0).
    for (int v = 0; v < 10; v++) begin
      do_reset();
      bus.daddr[0] = 32'hA0; bus.daddr[1] = 32'hB0;
      bus.iaddr[0] = 32'hC0; bus.iaddr[1] = 32'hD0;
      bus.dREN = vecs[v].dren; bus.dWEN = vecs[v].dwen; bus.iREN = vecs[v].iren;
      #1;
      chk($sformatf("vec%0d_idle_ren", v), bus.ramREN, 1'b0);
      @(negedge CLK);
      #1;
      chk($sformatf("vec%0d_grant", v), grant, vecs[v].exp_grant);
      chk($sformatf("vec%0d_ren", v), bus.ramREN, vecs[v].exp_ren);
      chk($sformatf("vec%0d_wen", v), bus.ramWEN, vecs[v].exp_wen);
      chk($sformatf("vec%0d_addr", v), bus.ramaddr, vecs[v].exp_addr);
    end

    // Read with ACCESS after three BUSY cycles.
    do_reset();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.ramstate = BUSY;
    #1;
    chk("rd_c0_ren", bus.ramREN, 1'b0);
    chk("rd_c0_dwait", bus.dwait, 2'b11);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("rd_c%0d_ren", c), bus.ramREN, 1'b1);
      chk($sformatf("rd_c%0d_addr", c), bus.ramaddr, 32'h100);
      chk($sformatf("rd_c%0d_dwait", c), bus.dwait, 2'b11);
    end
    @(negedge CLK);
    bus.ramstate = ACCESS;
    #1;
    chk("rd_acc_dwait", bus.dwait, 2'b10);
    @(negedge CLK);
    bus.dREN = '0; bus.ramstate = FREE;
    #1;
    chk("rd_after_dwait", bus.dwait, 2'b11);
    chk("rd_after_ren", bus.ramREN, 1'b0);

    // Both cores writing continuously alternate with an IDLE cycle between.
    do_reset();
    bus.dWEN = 2'b11; bus.ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        chk($sformatf("alt%0d_idle_wen", k), bus.ramWEN, 1'b0);
        chk($sformatf("alt%0d_idle_dwait", k), bus.dwait, 2'b11);
      end else begin
        chk($sformatf("alt%0d_wen", k), bus.ramWEN, 1'b1);
        chk($sformatf("alt%0d_grant", k), grant, ((k / 2) % 2 == 0) ? 2'b01 : 2'b11);
        chk($sformatf("alt%0d_dwait", k), bus.dwait, ((k / 2) % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(negedge CLK);
    end

    // Data before instruction within one core.
    do_reset();
    bus.dREN[0] = 1'b1; bus.iREN[0] = 1'b1; bus.ramstate = ACCESS;
    bus.daddr[0] = 32'h100; bus.iaddr[0] = 32'h300;
    @(negedge CLK);
    #1;
    chk("di_grant_d", grant, 2'b01);
    chk("di_dwait", bus.dwait, 2'b10);
    chk("di_iwait_hold", bus.iwait, 2'b11);
    @(negedge CLK);
    bus.dREN = '0;
    #1;
    chk("di_idle_iwait", bus.iwait, 2'b11);
    @(negedge CLK);
    #1;
    chk("di_grant_i", grant, 2'b00);
    chk("di_iaddr", bus.ramaddr, 32'h300);
    chk("di_iwait_low", bus.iwait, 2'b10);

    // Stuck RAM: watchdog after 255 BUSY cycles, then the other core.
    do_reset();
    bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20; bus.ramstate = BUSY;
    busy_cycles = 0; seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (timeout === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.ramREN === 1'b1) busy_cycles++;
      @(negedge CLK);
    end
    chk("to_seen", seen, 1'b1);
    chk("to_busy_cycles", busy_cycles, Timeout);
    chk("to_idle_ren", bus.ramREN, 1'b0);
    @(negedge CLK);
    #1;
    chk("to_pulse_len", timeout, 1'b0);
    chk("to_next_grant", grant, 2'b11);
    chk("to_next_addr", bus.ramaddr, 32'h20);

    // Reset in the middle of core 1's transaction (pointer is 1 here).
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("mrst_during_ren", bus.ramREN, 1'b0);
    chk("mrst_during_dwait", bus.dwait, 2'b11);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_ren", {bus.ramREN, bus.ramWEN}, 2'b00);
    chk("mrst_waits", {bus.dwait, bus.iwait}, 4'b1111);
    @(negedge CLK);
    #1;
    chk("mrst_ptr0_grant", grant, 2'b01);
    chk("mrst_ptr0_addr", bus.ramaddr, 32'h10);

    // Granted request withdrawn before ACCESS.
    do_reset();
    bus.dREN = 2'b10; bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h200; bus.ramstate = BUSY;
    @(negedge CLK);
    #1;
    chk("drop_grant", grant, 2'b11);
    chk("drop_ren", bus.ramREN, 1'b1);
    @(negedge CLK);
    bus.dREN = 2'b00;
    #1;
    chk("drop_ren_off", bus.ramREN, 1'b0);
    chk("drop_dwait", bus.dwait, 2'b11);
    @(negedge CLK);
    bus.dREN = 2'b11;
    #1;
    chk("drop_idle_ren", bus.ramREN, 1'b0);
    chk("drop_idle_dwait", bus.dwait, 2'b11);
    @(negedge CLK);
    #1;
    chk("drop_ptr_kept", grant, 2'b01);

    // Random traffic against the transaction-level model.
    do_reset();
    m_busy = 0; m_cpu = 0; m_data = 0; m_ptr = 0; m_to = 0; m_grant = '0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0]  e_dwait, e_iwait;
      logic        e_ren, e_wen, act, found;
      logic [31:0] e_addr, e_store;
      int          r;

      nRST = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < 2; k++) begin
        bus.dREN[k]   = bus.dREN[k] ^ ($urandom_range(0, 5) == 0);
        bus.dWEN[k]   = bus.dWEN[k] ^ ($urandom_range(0, 7) == 0);
        bus.iREN[k]   = bus.iREN[k] ^ ($urandom_range(0, 5) == 0);
        bus.daddr[k]  = $urandom;
        bus.dstore[k] = $urandom;
        bus.iaddr[k]  = $urandom;
      end
      bus.ramload = $urandom;
      r = $urandom_range(0, 7);
      bus.ramstate = (r < 2) ? ACCESS : (r < 4) ? FREE : (r < 6) ? BUSY : ERROR;
      #1;

      e_dwait = 2'b11; e_iwait = 2'b11; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
      act = m_data ? (bus.dREN[m_cpu] | bus.dWEN[m_cpu]) : bus.iREN[m_cpu];
      if (nRST && m_busy && act) begin
        if (m_data) begin
          e_wen = bus.dWEN[m_cpu];
          e_ren = bus.dREN[m_cpu] && !bus.dWEN[m_cpu];
          e_addr = bus.daddr[m_cpu];
          e_store = bus.dstore[m_cpu];
          if (bus.ramstate == ACCESS) e_dwait[m_cpu] = 1'b0;
        end else begin
          e_ren = 1;
          e_addr = bus.iaddr[m_cpu];
          if (bus.ramstate == ACCESS) e_iwait[m_cpu] = 1'b0;
        end
      end
      chk("rnd_ren", bus.ramREN, e_ren);
      chk("rnd_wen", bus.ramWEN, e_wen);
      chk("rnd_addr", bus.ramaddr, e_addr);
      chk("rnd_store", bus.ramstore, e_store);
      chk("rnd_dwait", bus.dwait, e_dwait);
      chk("rnd_iwait", bus.iwait, e_iwait);
      chk("rnd_grant", grant, m_grant);
      chk("rnd_timeout", timeout, m_to);
      chk("rnd_dload", bus.dload[cyc % 2], bus.ramload);
      chk("rnd_iload", bus.iload[(cyc + 1) % 2], bus.ramload);

      if (!nRST) begin
        m_busy = 0; m_ptr = 0; m_grant = '0; m_to = 0; m_cnt = 0;
      end else begin
        m_to = 0;
        if (!m_busy) begin
          found = 0;
          // Preference order: pointer core (data, instr), then the other core.
          for (int n = 0; n < 2 && !found; n++) begin
            bit c;
            c = (n == 0) ? m_ptr : !m_ptr;
            if (bus.dREN[c] || bus.dWEN[c]) begin
              found = 1; m_cpu = c; m_data = 1;
            end else if (bus.iREN[c]) begin
              found = 1; m_cpu = c; m_data = 0;
            end
          end
          if (found) begin
            m_busy = 1; m_cnt = 0; m_grant = {m_cpu, m_data};
          end
        end else if (!act) begin
          m_busy = 0;
        end else if (bus.ramstate == ACCESS) begin
          m_busy = 0; m_ptr = !m_cpu;
        end else begin
          m_cnt++;
          if (m_cnt == int'(Timeout)) begin
            m_busy = 0; m_ptr = !m_cpu; m_to = 1;
          end
        end
      end
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
